fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Keeps the program counter and issues word-aligned read requests to instruction memory over a valid/ready request channel.
- Receives in-order read responses and buffers them in a DEPTH-entry queue, each instruction tagged with its PC.
- Presents instructions to decode through an opcode valid/ready handshake. Supports branch/jump redirect with flush of stale fetches.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect and decode handshake.
// The master modport is the fetch unit's view; slave is the memory/decode/branch side.
interface fetch_unit_if #(
    parameter int N = 32
);
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [N-1:0] imem_req_addr;
    logic         imem_rsp_valid;
    logic [31:0]  imem_rsp_data;
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;
    logic         opcode_valid;
    logic         opcode_ready;
    logic [31:0]  opcode;
    logic [N-1:0] opcode_pc;

    modport master (
        output imem_req_valid, imem_req_addr, opcode_valid, opcode, opcode_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, opcode_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, opcode_valid, opcode, opcode_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, opcode_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order fetch into a small PC-tagged buffer,
// with redirect flush and a drain state that discards responses to abandoned requests.
module fetch_unit_chk #(
    parameter int CW = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          rsp_valid,
    input logic [CW-1:0] outstanding
);
    rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (outstanding != {CW{1'b0}}));
endmodule

module fetch_unit #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = {N{1'b0}},
    parameter int           DEPTH    = 2
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [N-1:0]  PC_STEP  = {{(N-3){1'b0}}, 3'b100};
    localparam logic [N-1:0]  PC_ALIGN = ~{{(N-2){1'b0}}, 2'b11};

    typedef enum logic [0:0] { S_FETCH = 1'b0, S_DRAIN = 1'b1 } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [31:0]   buf_data_q [DEPTH];
    logic [31:0]   buf_data_d [DEPTH];
    logic [N-1:0]  buf_pc_q [DEPTH];
    logic [N-1:0]  buf_pc_d [DEPTH];
    logic [N-1:0]  tag_q [DEPTH];
    logic [N-1:0]  tag_d [DEPTH];

    logic req_valid_s, req_fire_s, rsp_ok_s, push_s, pop_s, opcode_valid_s;

    // Handshake qualifiers; the credit sum counts both in-flight and buffered words.
    always_comb begin
        opcode_valid_s = (cnt_q != CNT_ZERO);
        req_valid_s    = (state_q == S_FETCH) && !bus.redirect_valid &&
                         (({1'b0, out_q} + {1'b0, cnt_q}) < (CW+1)'(DEPTH));
        req_fire_s     = req_valid_s && bus.imem_req_ready;
        rsp_ok_s       = bus.imem_rsp_valid && (out_q != CNT_ZERO);
        push_s         = rsp_ok_s && (state_q == S_FETCH) && !bus.redirect_valid;
        pop_s          = opcode_valid_s && bus.opcode_ready;
    end

    // Next-state: redirect flushes everything and converts in-flight requests into drops.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        buf_wr_d   = buf_wr_q;
        buf_rd_d   = buf_rd_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        buf_data_d = buf_data_q;
        buf_pc_d   = buf_pc_q;
        tag_d      = tag_q;
        if (bus.redirect_valid) begin
            pc_d     = bus.redirect_pc & PC_ALIGN;
            out_d    = rsp_ok_s ? (out_q - CNT_ONE) : out_q;
            drop_d   = out_d;
            cnt_d    = CNT_ZERO;
            buf_wr_d = PTR_ZERO;
            buf_rd_d = PTR_ZERO;
            tag_wr_d = PTR_ZERO;
            tag_rd_d = PTR_ZERO;
            state_d  = (out_d != CNT_ZERO) ? S_DRAIN : S_FETCH;
        end else begin
            if (req_fire_s) begin
                pc_d            = pc_q + PC_STEP;
                tag_d[tag_wr_q] = pc_q;
                tag_wr_d        = tag_wr_q + PTR_ONE;
            end else begin
                pc_d = pc_q;
            end
            if (push_s) begin
                buf_data_d[buf_wr_q] = bus.imem_rsp_data;
                buf_pc_d[buf_wr_q]   = tag_q[tag_rd_q];
                buf_wr_d             = buf_wr_q + PTR_ONE;
                tag_rd_d             = tag_rd_q + PTR_ONE;
            end else begin
                buf_wr_d = buf_wr_q;
            end
            if (pop_s) begin
                buf_rd_d = buf_rd_q + PTR_ONE;
            end else begin
                buf_rd_d = buf_rd_q;
            end
            cnt_d = cnt_q + CW'(push_s) - CW'(pop_s);
            out_d = out_q + CW'(req_fire_s) - CW'(rsp_ok_s);
            case (state_q)
                S_FETCH: begin
                    state_d = S_FETCH;
                end
                S_DRAIN: begin
                    if (rsp_ok_s) begin
                        drop_d  = drop_q - CNT_ONE;
                        state_d = (drop_q == CNT_ONE) ? S_FETCH : S_DRAIN;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            out_q    <= CNT_ZERO;
            drop_q   <= CNT_ZERO;
            cnt_q    <= CNT_ZERO;
            buf_wr_q <= PTR_ZERO;
            buf_rd_q <= PTR_ZERO;
            tag_wr_q <= PTR_ZERO;
            tag_rd_q <= PTR_ZERO;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            buf_wr_q <= buf_wr_d;
            buf_rd_q <= buf_rd_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
        end
    end

    // Buffer and tag storage; contents are only meaningful under the occupancy counters.
    always_ff @(posedge clk) begin
        buf_data_q <= buf_data_d;
        buf_pc_q   <= buf_pc_d;
        tag_q      <= tag_d;
    end

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = pc_q;
    assign bus.opcode_valid   = opcode_valid_s;
    assign bus.opcode         = opcode_valid_s ? buf_data_q[buf_rd_q] : 32'h0000_0000;
    assign bus.opcode_pc      = opcode_valid_s ? buf_pc_q[buf_rd_q] : {N{1'b0}};

    fetch_unit_chk #(.CW(CW)) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .rsp_valid   (bus.imem_rsp_valid),
        .outstanding (out_q)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model plus a transaction-level
// reference (pending address queue, delivered-PC queue, stale-response count).
module tb_fetch_unit;
    localparam int          N        = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if #(.N(N)) bus ();

    fetch_unit #(.N(N), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem_q [$];
    logic [31:0] m_buf [$];
    logic [31:0] m_pc;
    int          m_stale;
    bit          post_rst;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n              = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = $urandom;
        bus.imem_req_ready = 1'($urandom_range(0, 1));
        bus.opcode_ready   = 1'($urandom_range(0, 1));
        bus.redirect_valid = 1'b0;
        repeat (cycles - 1) @(negedge clk);
        mem_q.delete();
        m_buf.delete();
        m_stale  = 0;
        m_pc     = RESET_PC;
        post_rst = 1'b1;
    endtask

    // rsp_mode: 0 = memory silent, 1 = zero-wait, 2 = random latency
    task automatic step(input bit rdy, input bit req_rdy, input bit redir,
                        input logic [31:0] rpc, input int rsp_mode);
        bit          rsp;
        bit          exp_ov;
        bit          exp_req;
        logic [31:0] a;
        @(negedge clk);
        rst_n = 1'b1;
        case (rsp_mode)
            1:       rsp = (mem_q.size() > 0);
            2:       rsp = (mem_q.size() > 0) && ($urandom_range(0, 99) < 60);
            default: rsp = 1'b0;
        endcase
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_word(mem_q[0]) : $urandom;
        bus.opcode_ready   = rdy;
        bus.imem_req_ready = req_rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        #1;
        exp_ov  = (m_buf.size() > 0);
        exp_req = (m_stale == 0) && !redir && ((mem_q.size() + m_buf.size()) < DEPTH);
        check_val("opcode_valid", 32'(bus.opcode_valid), 32'(exp_ov));
        if (exp_ov) begin
            check_val("opcode_pc", bus.opcode_pc, m_buf[0]);
            check_val("opcode", bus.opcode, mem_word(m_buf[0]));
        end
        check_val("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
        if (exp_req) check_val("imem_req_addr", bus.imem_req_addr, m_pc);
        if (post_rst) begin
            check_val("rst_opcode", bus.opcode, 32'h0);
            check_val("rst_opcode_pc", bus.opcode_pc, 32'h0);
            post_rst = 1'b0;
        end
        // model the upcoming clock edge
        if (exp_ov && rdy) void'(m_buf.pop_front());
        if (rsp) begin
            a = mem_q.pop_front();
            if (m_stale > 0) m_stale--;
            else if (!redir) m_buf.push_back(a);
        end
        if (redir) begin
            m_buf.delete();
            m_stale = mem_q.size();
            m_pc    = rpc & 32'hFFFF_FFFC;
        end else if (exp_req && req_rdy) begin
            mem_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.opcode_ready   = 1'b0;
        m_pc               = RESET_PC;
        m_stale            = 0;
        post_rst           = 1'b0;

        do_reset(2);
        repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
        repeat (5)  step(1'b0, 1'b1, 1'b0, 32'h0, 1);
        repeat (8)  step(1'b1, 1'b1, 1'b0, 32'h0, 1);

        do_reset(1);
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // two requests left in flight, then redirect to an unaligned target
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0203, 0);
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // redirect together with a response and a decode pop
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // PC wrap across the top of the address space
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF7, 1);
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // reset in the middle of streaming
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 0);
        do_reset(1);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1 + $urandom_range(0, 1));
            end else begin
                step(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70),
                     ($urandom_range(0, 99) < 3), $urandom, 2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
